// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and types
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int XLEN      = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy flags with set-over-clear priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NumRegs      = REG_COUNT,
  parameter int AddressWidth = $clog2(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    set,
  input  logic [AddressWidth-1:0] set_addr,
  input  logic [NumRegs-1:0]      clear,
  output logic [NumRegs-1:0]      busy_o
);

  logic [NumRegs-1:0] busy_q;

  // Set beats clear so a new producer issued during the old producer's writeback stays tracked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q[0] <= 1'b0;
      for (int r = 1; r < NumRegs; r++) begin
        if (set && (set_addr == AddressWidth'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (clear[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NumRegs      = REG_COUNT,
  parameter int DataWidth    = XLEN,
  parameter int AddressWidth = $clog2(NumRegs),
  parameter int NumRdPorts   = 2,
  parameter int NumWrPorts   = 1,
  parameter int Bypass       = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumWrPorts-1:0]              wr_en_i,
  input  logic [NumWrPorts*AddressWidth-1:0] wr_addr_i,
  input  logic [NumWrPorts*DataWidth-1:0]    wr_data_i,
  input  logic [NumRdPorts*AddressWidth-1:0] rd_addr_i,
  output logic [NumRdPorts*DataWidth-1:0]    rd_data_o,
  input  logic                               busy_set_i,
  input  logic [AddressWidth-1:0]            busy_addr_i,
  output logic [NumRegs-1:0]                 busy_o
);

  logic [DataWidth-1:0]    mem_q     [NumRegs];
  logic [AddressWidth-1:0] wr_addr_a [NumWrPorts];
  logic [DataWidth-1:0]    wr_data_a [NumWrPorts];
  logic [NumWrPorts-1:0]   wr_vld;
  logic [AddressWidth-1:0] rd_addr_a [NumRdPorts];
  logic [DataWidth-1:0]    rd_data_a [NumRdPorts];
  logic [NumRegs-1:0]      clear;

  for (genvar k = 0; k < NumWrPorts; k++) begin : g_wr
    assign wr_addr_a[k] = wr_addr_i[k*AddressWidth +: AddressWidth];
    assign wr_data_a[k] = wr_data_i[k*DataWidth +: DataWidth];
    assign wr_vld[k]    = wr_en_i[k] && (wr_addr_a[k] != '0);
  end

  for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
    assign rd_addr_a[p] = rd_addr_i[p*AddressWidth +: AddressWidth];
    assign rd_data_o[p*DataWidth +: DataWidth] = rd_data_a[p];
  end

  // Ascending port order: the last nonblocking assignment, i.e. the highest port, wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRegs; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NumWrPorts; k++) begin
        if (wr_vld[k]) begin
          mem_q[wr_addr_a[k]] <= wr_data_a[k];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NumRdPorts; p++) begin
      rd_data_a[p] = (rd_addr_a[p] == '0) ? '0 : mem_q[rd_addr_a[p]];
      if ((Bypass != 0) && !rst_i) begin
        for (int k = 0; k < NumWrPorts; k++) begin
          if (wr_vld[k] && (wr_addr_a[k] == rd_addr_a[p])) begin
            rd_data_a[p] = wr_data_a[k];
          end
        end
      end
    end
  end

  always_comb begin
    clear = '0;
    for (int k = 0; k < NumWrPorts; k++) begin
      if (wr_vld[k]) begin
        clear[wr_addr_a[k]] = 1'b1;
      end
    end
  end

  regfile_scoreboard #(
    .NumRegs      (NumRegs),
    .AddressWidth (AddressWidth)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set      (busy_set_i),
    .set_addr (busy_addr_i),
    .clear    (clear),
    .busy_o   (busy_o)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation RISC-V core (dual-issue and pipelined configurations). It provides N combinational read ports and M synchronous write ports, with optional write-to-read bypass and a per-register busy scoreboard for hazard detection. Register x0 is hardwired to zero and is never busy. The block sits between decode (reads, busy set) and writeback (writes, busy clear).

## Interface
Parameters:
- NumRegs, 32, number of architectural registers (power of two, ≥2)
- DataWidth, 32, register width in bits
- AddressWidth, $clog2(NumRegs), register index width
- NumRdPorts, 2, number of read ports (1–6)
- NumWrPorts, 1, number of write ports (1–3)
- Bypass, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-write value

Ports:
- clk_i  in  1  clock. One clock domain; all state updates on the rising edge.
- rst_i  in  1  reset. Synchronous and active-high.
- wr_en_i  in  NumWrPorts  per-port write enable
- wr_addr_i  in  NumWrPorts*AddressWidth  packed write addresses; port k occupies bits [k*AW +: AW]
- wr_data_i  in  NumWrPorts*DataWidth  packed write data
- rd_addr_i  in  NumRdPorts*AddressWidth  packed read addresses
- rd_data_o  out  NumRdPorts*DataWidth  packed read data
- busy_set_i  in  1  mark the destination of a newly issued instruction as busy
- busy_addr_i  in  AddressWidth  register to mark busy
- busy_o  out  NumRegs  per-register busy flag; bit 0 is always 0

## Operation
- Reset (rst_i=1 at an edge): registers 1..NumRegs-1 are set to 0, and all busy bits are set to 0. All writes and busy_set inputs in that cycle are ignored.
- Write: at an edge with rst_i=0, each port k with wr_en_i[k]=1 and a nonzero address writes its data.
  - Writes to x0 are discarded.
- Write conflict: when more than one enabled port targets the same address, the highest-index port wins. This rule applies to the array update and to the bypass path.
- Read: rd_data_o is combinational from rd_addr_i. Address 0 always returns 0.
- Bypass=1: a read whose address matches an enabled nonzero write port in the same cycle (rst_i=0) returns that port's wr_data_i. The conflict rule applies.
  - While rst_i=1, bypass is suppressed and reads return array contents.
- Bypass=0: reads always return the array contents as of the last edge.
- Scoreboard:
  - An enabled nonzero write to register r clears busy[r] at the edge.
  - busy_set_i with a nonzero busy_addr_i sets busy[busy_addr_i] at the edge.
  - busy_set_i targeting x0 is ignored.
- Simultaneous set and clear of the same register: set wins, so busy=1 after the edge. This covers a new producer issued in the same cycle the old producer writes back.
- Writes to a non-busy register are legal and leave busy at 0.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: new data is visible on non-bypassed reads in the cycle after the edge.
- Busy latency: busy_o reflects set/clear in the cycle after the edge. busy_o is a registered output with no combinational path from any input.
- After reset: rd_data_o = 0 for all addresses; busy_o = 0.
- Reset mid-operation: in-flight writes are lost, and the scoreboard clears regardless of outstanding producers. Upstream must flush the pipeline with rst_i.
- Critical path: rd_addr_i → read mux → bypass compare/mux → rd_data_o. Bypass compare depth scales with NumWrPorts.

## Structure
- Shared package regfile_pkg:
  - default parameter constants (REG_COUNT, XLEN)
  - typedef reg_addr_t (logic [AddressWidth-1:0])
  - typedef reg_data_t
  - constant ZERO_REG = '0
  - The core's decode and writeback stages import the same package.
- Sub-module regfile_scoreboard: holds the NumRegs busy bits and the set/clear/priority logic; interface clk_i, rst_i, set, set_addr, clear vector, busy_o.
- The array and bypass logic are in regfile_mp. Write-port priority is resolved by a loop in ascending port order, with last assignment winning.
- Storage is flops (no RAM inference), because there are multiple write ports and reads are combinational.

## Test plan
- Reset then read: rst_i=1 for 1 cycle, then read x0..x31 → all 0; busy_o=0.
- Write/read and x0: write 0xDEADBEEF to x5 via port 0 → next cycle rd x5 = 0xDEADBEEF. Write 0x1234 to x0 → rd x0 = 0.
- Bypass: with Bypass=1, write 0xA5A5A5A5 to x7 and read x7 in the same cycle → 0xA5A5A5A5. With Bypass=0, the same stimulus returns the old value 0 in that cycle and 0xA5A5A5A5 in the next.
- Write conflict: NumWrPorts=2, port0 writes 0x11 to x3 and port1 writes 0x22 to x3 in the same cycle → bypass read = 0x22 and next-cycle read = 0x22.
- Scoreboard:
  - busy_set x9 → busy_o[9]=1 next cycle.
  - Write x9 → busy_o[9]=0.
  - Set x9 and write x9 in the same cycle → busy_o[9]=1.
  - busy_set x0 → busy_o[0]=0.
- Reset mid-operation: x4=0x55 and busy[4]=1. Assert rst_i together with a write of 0x66 to x4 → next cycle x4=0 and busy[4]=0. The bypass read in the reset cycle returns 0x55.
